// File: rtl/st3_rr_arbiter.sv
// ----------------------------------------------------------------------------
// st3_rr_arbiter
//
// Round-robin arbiter that merges three 8-bit valid/ready source streams onto
// one registered 16-bit output stream. A grant lasts until MAX_BURST beats have
// been accepted or the granted source goes idle while a slot is free. Between
// grants there is always one IDLE cycle in which the next source is chosen.
//
// State table
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_IDLE  | no grant; pick first requester in circular order after last_id
//   S_GRANT | grant_id owns the output; beats accepted while a slot is free
//
// Ports
//   clk                 rising-edge clock for all logic
//   rst_in              synchronous active-high reset
//   data_k / valid_k    source k (k = 1..3) data and valid
//   ready_k             source k ready (only the granted source can see 1)
//   data_out            registered output word {6'b0, tag[1:0], data[7:0]}
//   valid_out           output word valid
//   ready_out           downstream ready
//   grant_id            current grant: 0 none, 1..3 source number
// ----------------------------------------------------------------------------
module st3_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter bit          TAG_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [7:0]  data_1,
    input  logic        valid_1,
    output logic        ready_1,
    input  logic [7:0]  data_2,
    input  logic        valid_2,
    output logic        ready_2,
    input  logic [7:0]  data_3,
    input  logic        valid_3,
    output logic        ready_3,
    output logic [15:0] data_out,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [1:0]  grant_id
);

    localparam logic [7:0] L_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant_id;
    logic [1:0]  w_grant_nxt;
    logic [1:0]  r_last_id;
    logic [1:0]  w_last_nxt;
    logic [7:0]  r_beat_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_data_out;
    logic [15:0] w_data_nxt;
    logic        r_valid_out;
    logic        w_valid_nxt;

    logic [1:0]  w_pick;
    logic        w_any_valid;
    logic        w_slot_free;
    logic        w_can_take;
    logic        w_gnt_valid;
    logic [7:0]  w_gnt_data;
    logic [7:0]  w_cnt_inc;
    logic        w_xfer;
    logic        w_burst_done;
    logic        w_release;
    logic [1:0]  w_tag;

    // ------------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------------
    assign w_any_valid = valid_1 | valid_2 | valid_3;

    // A slot is free when the output register is empty or being drained now.
    assign w_slot_free = !r_valid_out || ready_out;

    // Readies are forced low during reset even though reset is synchronous,
    // so no beat can slip in on the reset edge.
    assign w_can_take  = !rst_in && (r_state == S_GRANT) && w_slot_free;

    assign ready_1 = w_can_take && (r_grant_id == 2'd1);
    assign ready_2 = w_can_take && (r_grant_id == 2'd2);
    assign ready_3 = w_can_take && (r_grant_id == 2'd3);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_data  = 8'h00;
        case (r_grant_id)
            2'd1: begin
                w_gnt_valid = valid_1;
                w_gnt_data  = data_1;
            end
            2'd2: begin
                w_gnt_valid = valid_2;
                w_gnt_data  = data_2;
            end
            2'd3: begin
                w_gnt_valid = valid_3;
                w_gnt_data  = data_3;
            end
            default: begin
                w_gnt_valid = 1'b0;
                w_gnt_data  = 8'h00;
            end
        endcase
    end

    assign w_xfer       = w_can_take && w_gnt_valid;
    assign w_cnt_inc    = r_beat_cnt + 8'd1;
    assign w_burst_done = (w_cnt_inc == L_MAX_BURST);

    // Release on the final beat of a burst, or when the owner is idle while it
    // could have sent. A source stalled by backpressure keeps its grant.
    assign w_release    = (w_xfer && w_burst_done) || (w_can_take && !w_gnt_valid);

    assign w_tag        = TAG_EN ? r_grant_id : 2'b00;

    // ------------------------------------------------------------------------
    // Round-robin pick: first requester after last_id, wrapping 3 -> 1.
    // last_id is never 0 (reset value is 3), so default covers last_id == 3.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick = 2'd0;
        case (r_last_id)
            2'd1: begin
                if      (valid_2) w_pick = 2'd2;
                else if (valid_3) w_pick = 2'd3;
                else if (valid_1) w_pick = 2'd1;
            end
            2'd2: begin
                if      (valid_3) w_pick = 2'd3;
                else if (valid_1) w_pick = 2'd1;
                else if (valid_2) w_pick = 2'd2;
            end
            default: begin
                if      (valid_1) w_pick = 2'd1;
                else if (valid_2) w_pick = 2'd2;
                else if (valid_3) w_pick = 2'd3;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_id;
        w_cnt_nxt   = r_beat_cnt;
        w_data_nxt  = r_data_out;
        w_valid_nxt = r_valid_out;

        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_grant_id;
                    w_grant_nxt = 2'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'd0;
            end
        endcase

        // A new beat overwrites a word being drained in the same cycle, which
        // keeps throughput at one beat per cycle.
        if (w_xfer) begin
            w_data_nxt  = {6'b000000, w_tag, w_gnt_data};
            w_valid_nxt = 1'b1;
        end else if (r_valid_out && ready_out) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_grant_id  <= 2'd0;
            r_last_id   <= 2'd3;
            r_beat_cnt  <= 8'd0;
            r_data_out  <= 16'h0000;
            r_valid_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_id  <= w_grant_nxt;
            r_last_id   <= w_last_nxt;
            r_beat_cnt  <= w_cnt_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign grant_id  = r_grant_id;

endmodule
